// File: rtl/vsa_memsys.sv
// Instruction/data memory subsystem for the 12-bit VSA core.
// A valid/ready loader fills imem then dmem, then releases the core.
module vsa_memsys #(
  parameter int IDEPTH = 32,
  parameter int DDEPTH = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  PC,
  output logic [11:0] instruction,
  input  logic [4:0]  ALUOutput,
  input  logic [4:0]  dataout,
  input  logic        wr,
  output logic [4:0]  datain,
  input  logic        ld_valid,
  input  logic [11:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        cpu_run,
  output logic [1:0]  phase,
  output logic [5:0]  store_cnt
);

  localparam logic [1:0] PH_LI  = 2'd0;
  localparam logic [1:0] PH_LD  = 2'd1;
  localparam logic [1:0] PH_RUN = 2'd2;

  logic [11:0] imem [IDEPTH];
  logic [4:0]  dmem [DDEPTH];

  logic [1:0] phase_q, phase_d;
  logic [4:0] lcnt_q, lcnt_d;
  logic [5:0] store_cnt_q, store_cnt_d;
  logic       cpu_run_q, cpu_run_d;

  logic       xfer;
  logic       last;
  logic       imem_we;
  logic       dmem_we;
  logic [4:0] dmem_waddr;
  logic [4:0] dmem_wdata;

  assign ld_ready    = (phase_q != PH_RUN);
  assign xfer        = ld_valid & ld_ready;
  assign last        = ld_last | (lcnt_q == 5'd31);
  assign phase       = phase_q;
  assign cpu_run     = cpu_run_q;
  assign store_cnt   = store_cnt_q;
  assign instruction = (phase_q == PH_RUN) ? imem[PC] : 12'd0;
  assign datain      = dmem[ALUOutput];

  always_comb begin
    phase_d     = phase_q;
    lcnt_d      = lcnt_q;
    store_cnt_d = store_cnt_q;
    imem_we     = 1'b0;
    dmem_we     = 1'b0;
    dmem_waddr  = ALUOutput;
    dmem_wdata  = dataout;
    unique case (phase_q)
      PH_LI: begin
        if (xfer) begin
          imem_we = 1'b1;
          lcnt_d  = last ? 5'd0 : lcnt_q + 5'd1;
          if (last) phase_d = PH_LD;
        end
      end
      PH_LD: begin
        if (xfer) begin
          dmem_we    = 1'b1;
          dmem_waddr = lcnt_q;
          dmem_wdata = ld_data[4:0];
          lcnt_d     = last ? 5'd0 : lcnt_q + 5'd1;
          if (last) phase_d = PH_RUN;
        end
      end
      PH_RUN: begin
        if (wr) begin
          dmem_we = 1'b1;
          if (store_cnt_q != 6'd63) store_cnt_d = store_cnt_q + 6'd1;
        end
      end
      default: phase_d = PH_LI;
    endcase
    // Reset wins, but memory contents are deliberately preserved
    if (reset) begin
      phase_d     = PH_LI;
      lcnt_d      = 5'd0;
      store_cnt_d = 6'd0;
      imem_we     = 1'b0;
      dmem_we     = 1'b0;
    end
    cpu_run_d = (phase_d == PH_RUN);
  end

  always_ff @(posedge clock) begin
    phase_q     <= phase_d;
    lcnt_q      <= lcnt_d;
    store_cnt_q <= store_cnt_d;
    cpu_run_q   <= cpu_run_d;
  end

  always_ff @(posedge clock) begin
    if (imem_we) imem[lcnt_q] <= ld_data;
    if (dmem_we) dmem[dmem_waddr] <= dmem_wdata;
  end

endmodule

// File: tb/tb_vsa_memsys.sv
// Directed bench for vsa_memsys: loader phases, reads, stores, reset.
module tb_vsa_memsys;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  PC;
  logic [11:0] instruction;
  logic [4:0]  ALUOutput;
  logic [4:0]  dataout;
  logic        wr;
  logic [4:0]  datain;
  logic        ld_valid;
  logic [11:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        cpu_run;
  logic [1:0]  phase;
  logic [5:0]  store_cnt;

  int tests = 0;
  int fails = 0;

  vsa_memsys dut (
    .clock(clock), .reset(reset), .PC(PC), .instruction(instruction),
    .ALUOutput(ALUOutput), .dataout(dataout), .wr(wr), .datain(datain),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .cpu_run(cpu_run), .phase(phase),
    .store_cnt(store_cnt)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ld_word(input logic [11:0] d, input logic l);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = l;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (phase !== 2'd0) begin
      fails++; $display("FAIL rst_phase got %0d exp 0", phase);
    end
    tests++;
    if (cpu_run !== 1'b0 || ld_ready !== 1'b1) begin
      fails++; $display("FAIL rst_run_rdy got %b%b exp 01", cpu_run, ld_ready);
    end
    tests++;
    if (store_cnt !== 6'd0 || instruction !== 12'd0) begin
      fails++;
      $display("FAIL rst_cnt_ins got %0d/%h exp 0/000", store_cnt, instruction);
    end
  endtask

  task automatic test_small_load();
    ld_word(12'h604, 1'b0);
    ld_word(12'h80A, 1'b0);
    tests++;
    if (phase !== 2'd0) begin
      fails++; $display("FAIL sm_ph_e2 got %0d exp 0", phase);
    end
    ld_word(12'hE00, 1'b1);
    tests++;
    if (phase !== 2'd1) begin
      fails++; $display("FAIL sm_ph_e3 got %0d exp 1", phase);
    end
    ld_word(12'd7, 1'b0);
    ld_word(12'd9, 1'b1);
    tests++;
    if (phase !== 2'd2 || cpu_run !== 1'b1) begin
      fails++; $display("FAIL sm_run got %0d/%b exp 2/1", phase, cpu_run);
    end
    PC = 5'd1; ALUOutput = 5'd1; #1;
    tests++;
    if (instruction !== 12'h80A) begin
      fails++; $display("FAIL sm_ins1 got %h exp 80a", instruction);
    end
    tests++;
    if (datain !== 5'd9) begin
      fails++; $display("FAIL sm_dat1 got %0d exp 9", datain);
    end
    PC = 5'd2; ALUOutput = 5'd0; #1;
    tests++;
    if (instruction !== 12'hE00 || datain !== 5'd7) begin
      fails++;
      $display("FAIL sm_ins2_dat0 got %h/%0d exp e00/7", instruction, datain);
    end
  endtask

  task automatic test_full_load();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      ld_word(12'(i), 1'b0);
      if (i == 30) begin
        tests++;
        if (phase !== 2'd0) begin
          fails++; $display("FAIL fl_ph31 got %0d exp 0", phase);
        end
      end
    end
    tests++;
    if (phase !== 2'd1) begin
      fails++; $display("FAIL fl_ph32 got %0d exp 1", phase);
    end
    for (int i = 0; i < 32; i++) begin
      ld_word(12'(i & 31), 1'b0);
      if (i == 30) begin
        tests++;
        if (phase !== 2'd1 || cpu_run !== 1'b0) begin
          fails++; $display("FAIL fl_ph63 got %0d/%b exp 1/0", phase, cpu_run);
        end
      end
    end
    tests++;
    if (phase !== 2'd2 || cpu_run !== 1'b1) begin
      fails++; $display("FAIL fl_ph64 got %0d/%b exp 2/1", phase, cpu_run);
    end
    PC = 5'd31; ALUOutput = 5'd31; #1;
    tests++;
    if (instruction !== 12'd31 || datain !== 5'd31) begin
      fails++;
      $display("FAIL fl_31 got %h/%0d exp 01f/31", instruction, datain);
    end
    PC = 5'd0; ALUOutput = 5'd17; #1;
    tests++;
    if (instruction !== 12'd0 || datain !== 5'd17) begin
      fails++;
      $display("FAIL fl_0_17 got %h/%0d exp 000/17", instruction, datain);
    end
  endtask

  task automatic test_backpressure();
    int gap;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ld_word(12'h100 + 12'(i), i == 3);
      gap = $urandom_range(1, 3);
      ld_data = 12'hABC;
      repeat (gap) tick();
      if (i == 2) begin
        tests++;
        if (phase !== 2'd0) begin
          fails++; $display("FAIL bp_gap_ph got %0d exp 0", phase);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        wr = 1'b1; ALUOutput = 5'd10; dataout = 5'd0;
      end
      ld_word(12'd20 + 12'(i), i == 2);
      wr = 1'b0;
      if (i < 2) begin
        ld_data = 12'h01F;
        repeat ($urandom_range(1, 3)) tick();
      end
    end
    tests++;
    if (phase !== 2'd2 || store_cnt !== 6'd0) begin
      fails++; $display("FAIL bp_run got %0d/%0d exp 2/0", phase, store_cnt);
    end
    ALUOutput = 5'd10; #1;
    tests++;
    if (datain !== 5'd10) begin
      fails++; $display("FAIL bp_bound_st got %0d exp 10", datain);
    end
    for (int i = 0; i < 4; i++) begin
      PC = 5'(i); #1;
      tests++;
      if (instruction !== 12'h100 + 12'(i)) begin
        fails++;
        $display("FAIL bp_imem%0d got %h exp %h", i, instruction, 12'h100 + 12'(i));
      end
    end
    for (int i = 0; i < 4; i++) begin
      ALUOutput = 5'(i); #1;
      tests++;
      if (datain !== ((i < 3) ? 5'(20 + i) : 5'd3)) begin
        fails++; $display("FAIL bp_dmem%0d got %0d", i, datain);
      end
    end
    PC = 5'd4; #1;
    tests++;
    if (instruction !== 12'd4) begin
      fails++; $display("FAIL bp_imem4 got %h exp 004", instruction);
    end
    ld_valid = 1'b1; ld_data = 12'hFFF; ld_last = 1'b1;
    repeat (3) tick();
    tests++;
    if (ld_ready !== 1'b0 || phase !== 2'd2) begin
      fails++; $display("FAIL bp_run_rdy got %b/%0d exp 0/2", ld_ready, phase);
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    PC = 5'd0; ALUOutput = 5'd0; #1;
    tests++;
    if (instruction !== 12'h100 || datain !== 5'd20) begin
      fails++;
      $display("FAIL bp_run_mem got %h/%0d exp 100/20", instruction, datain);
    end
  endtask

  task automatic test_store_run();
    ALUOutput = 5'd5; dataout = 5'd21; wr = 1'b1; #1;
    tests++;
    if (datain !== 5'd5) begin
      fails++; $display("FAIL st_old got %0d exp 5", datain);
    end
    tick();
    wr = 1'b0; #1;
    tests++;
    if (datain !== 5'd21 || store_cnt !== 6'd1) begin
      fails++; $display("FAIL st_new got %0d/%0d exp 21/1", datain, store_cnt);
    end
    wr = 1'b1; ALUOutput = 5'd6; dataout = 5'd6;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (i == 61) begin
        tests++;
        if (store_cnt !== 6'd63) begin
          fails++; $display("FAIL st_cnt63 got %0d exp 63", store_cnt);
        end
      end
    end
    wr = 1'b0;
    tests++;
    if (store_cnt !== 6'd63) begin
      fails++; $display("FAIL st_sat got %0d exp 63", store_cnt);
    end
  endtask

  task automatic test_store_outside();
    do_reset();
    tests++;
    if (store_cnt !== 6'd0 || phase !== 2'd0 || cpu_run !== 1'b0) begin
      fails++;
      $display("FAIL so_rst got %0d/%0d/%b exp 0/0/0", store_cnt, phase, cpu_run);
    end
    wr = 1'b1; ALUOutput = 5'd2; dataout = 5'd31;
    tick();
    wr = 1'b0;
    tests++;
    if (datain !== 5'd22 || store_cnt !== 6'd0) begin
      fails++; $display("FAIL so_ign got %0d/%0d exp 22/0", datain, store_cnt);
    end
    tests++;
    if (instruction !== 12'd0) begin
      fails++; $display("FAIL so_ins got %h exp 000", instruction);
    end
  endtask

  task automatic test_reset_mid_load();
    ld_word(12'hA00, 1'b0);
    ld_word(12'hA01, 1'b1);
    ld_word(12'd1, 1'b0);
    ld_word(12'd2, 1'b0);
    tests++;
    if (phase !== 2'd1) begin
      fails++; $display("FAIL rm_pre got %0d exp 1", phase);
    end
    do_reset();
    tests++;
    if (phase !== 2'd0 || cpu_run !== 1'b0 || ld_ready !== 1'b1) begin
      fails++;
      $display("FAIL rm_rst got %0d/%b/%b exp 0/0/1", phase, cpu_run, ld_ready);
    end
    ld_word(12'hB00, 1'b1);
    tests++;
    if (phase !== 2'd1) begin
      fails++; $display("FAIL rm_ph1 got %0d exp 1", phase);
    end
    ld_word(12'd3, 1'b1);
    tests++;
    if (phase !== 2'd2 || cpu_run !== 1'b1) begin
      fails++; $display("FAIL rm_run got %0d/%b exp 2/1", phase, cpu_run);
    end
    PC = 5'd0; ALUOutput = 5'd0; #1;
    tests++;
    if (instruction !== 12'hB00 || datain !== 5'd3) begin
      fails++; $display("FAIL rm_0 got %h/%0d exp b00/3", instruction, datain);
    end
    PC = 5'd1; ALUOutput = 5'd1; #1;
    tests++;
    if (instruction !== 12'hA01 || datain !== 5'd2) begin
      fails++; $display("FAIL rm_1 got %h/%0d exp a01/2", instruction, datain);
    end
    PC = 5'd2; ALUOutput = 5'd2; #1;
    tests++;
    if (instruction !== 12'h102 || datain !== 5'd22) begin
      fails++; $display("FAIL rm_2 got %h/%0d exp 102/22", instruction, datain);
    end
  endtask

  initial begin
    reset = 1'b1; PC = '0; ALUOutput = '0; dataout = '0; wr = 1'b0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    tick();
    test_reset();
    test_small_load();
    test_full_load();
    test_backpressure();
    test_store_run();
    test_store_outside();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
